// File: rtl/phase_sequencer.sv
// Fixed-cycle traffic phase sequencer: INIT/GREEN/YELLOW/ALLRED/FLASH with
// per-table, per-phase second durations, demand-skipping and pedestrian walk.
module phase_sequencer #(
  parameter int N_PHASES      = 4,
  parameter int N_TABLES      = 4,
  parameter int TW            = 8,
  parameter int TICKS_PER_SEC = 10000,
  localparam int PW  = (N_PHASES > 1) ? $clog2(N_PHASES) : 1,
  localparam int TBW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
  input  logic                CLK,
  input  logic                reset_general,
  input  logic                enable_general,
  input  logic [TBW-1:0]      tbl_sel,
  input  logic [N_PHASES-1:0] demand,
  input  logic [N_PHASES-1:0] ped_req,
  input  logic                cfg_we,
  input  logic [TBW-1:0]      cfg_tbl,
  input  logic [PW-1:0]       cfg_phase,
  input  logic [1:0]          cfg_field,
  input  logic [TW-1:0]       cfg_data,
  output logic [N_PHASES-1:0] green,
  output logic [N_PHASES-1:0] yellow,
  output logic [N_PHASES-1:0] red,
  output logic [N_PHASES-1:0] walk,
  output logic [PW-1:0]       cur_phase,
  output logic [TBW-1:0]      cur_tbl,
  output logic [2:0]          state
);

  localparam int PSW = $clog2(TICKS_PER_SEC + 1);
  localparam int DW  = (TW > 3) ? TW : 3;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_ALLRED = 3'd3,
    S_FLASH  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [TBW-1:0]      tblsel_q, tblsel_d;
  logic [N_PHASES-1:0] latch_q, latch_d;
  logic [N_PHASES-1:0] mid_q, mid_d;
  logic [PSW-1:0]      presc_q, presc_d;
  logic [DW-1:0]       sec_q, sec_d;
  logic [DW-1:0]       dur_q, dur_d;
  logic [N_PHASES-1:0] walk_q, walk_d;
  logic [N_PHASES-1:0] green_q, green_d;
  logic [N_PHASES-1:0] yellow_q, yellow_d;
  logic [N_PHASES-1:0] red_q, red_d;
  logic [TW-1:0]       tab_q [N_TABLES][N_PHASES][3];
  logic [TW-1:0]       tab_d [N_TABLES][N_PHASES][3];

  logic                sec_tick;
  logic                done;
  logic                entry;
  logic [PW-1:0]       nxt_phase;
  logic [PW-1:0]       idx;
  logic [N_PHASES-1:0] req;
  logic [1:0]          fld;
  logic [DW-1:0]       min_dur;
  logic [DW-1:0]       raw;

  assign green     = green_q;
  assign yellow    = yellow_q;
  assign red       = red_q;
  assign walk      = walk_q;
  assign cur_phase = phase_q;
  assign cur_tbl   = tblsel_q;
  assign state     = state_q;

  always_comb begin
    tab_d = tab_q;
    if (cfg_we && (cfg_field != 2'd3) && (32'(cfg_phase) < N_PHASES))
      tab_d[cfg_tbl][cfg_phase][cfg_field] = cfg_data;
  end

  // Scan downward so the smallest forward distance from cur_phase wins;
  // distance N_PHASES lets the current phase be re-served when it is the only one.
  always_comb begin
    req       = demand | latch_q;
    nxt_phase = PW'((32'(phase_q) + 32'd1) % N_PHASES);
    idx       = '0;
    for (int unsigned i = N_PHASES; i >= 1; i--) begin
      idx = PW'((32'(phase_q) + i) % N_PHASES);
      if (req[idx]) nxt_phase = idx;
    end
  end

  always_comb begin
    sec_tick = (presc_q == PSW'(TICKS_PER_SEC - 1));
    done     = sec_tick && (sec_q == dur_q - DW'(1));

    state_d  = state_q;
    phase_d  = phase_q;
    tblsel_d = tblsel_q;
    entry    = 1'b0;

    if (!enable_general) begin
      state_d = S_FLASH;
      entry   = (state_q != S_FLASH);
    end else begin
      case (state_q)
        S_INIT: if (done) begin
          state_d  = S_GREEN;
          phase_d  = '0;
          tblsel_d = tbl_sel;
          entry    = 1'b1;
        end
        S_GREEN: if (done) begin
          state_d = S_YELLOW;
          entry   = 1'b1;
        end
        S_YELLOW: if (done) begin
          state_d = S_ALLRED;
          entry   = 1'b1;
        end
        S_ALLRED: if (done) begin
          state_d = S_GREEN;
          phase_d = nxt_phase;
          if (nxt_phase == '0) tblsel_d = tbl_sel;
          entry   = 1'b1;
        end
        default: begin
          state_d = S_INIT;
          entry   = 1'b1;
        end
      endcase
    end

    presc_d = sec_tick ? '0 : presc_q + PSW'(1);
    sec_d   = sec_tick ? sec_q + DW'(1) : sec_q;
    dur_d   = dur_q;
    walk_d  = walk_q;
    latch_d = latch_q | ped_req;
    mid_d   = mid_q;
    fld     = 2'd0;
    min_dur = DW'(1);
    raw     = '0;

    // A request for the phase currently in green is remembered separately so
    // that clearing the served latch on green exit does not lose it.
    if (state_q == S_GREEN)
      mid_d[phase_q] = mid_q[phase_q] | ped_req[phase_q];

    if (entry) begin
      presc_d = '0;
      sec_d   = '0;
      walk_d  = '0;
      mid_d   = '0;
      if (state_q == S_GREEN)
        latch_d[phase_q] = mid_q[phase_q] | ped_req[phase_q];
      case (state_d)
        S_GREEN: begin
          fld             = 2'd0;
          walk_d[phase_d] = latch_q[phase_d];
          if (latch_q[phase_d]) min_dur = DW'(5);
        end
        S_YELLOW: fld = 2'd1;
        S_ALLRED: fld = 2'd2;
        default:  fld = 2'd0;
      endcase
      raw = DW'(tab_q[tblsel_d][phase_d][fld]);
      if (state_d == S_GREEN || state_d == S_YELLOW || state_d == S_ALLRED)
        dur_d = (raw < min_dur) ? min_dur : raw;
      else
        dur_d = DW'(1);
    end

    red_d    = '1;
    green_d  = '0;
    yellow_d = '0;
    case (state_d)
      S_GREEN: begin
        green_d[phase_d] = 1'b1;
        red_d[phase_d]   = 1'b0;
      end
      S_YELLOW: begin
        yellow_d[phase_d] = 1'b1;
        red_d[phase_d]    = 1'b0;
      end
      S_FLASH: begin
        red_d    = '0;
        yellow_d = entry ? '1 : (sec_tick ? ~yellow_q : yellow_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_general) begin
      state_q  <= S_INIT;
      phase_q  <= '0;
      tblsel_q <= '0;
      latch_q  <= '0;
      mid_q    <= '0;
      presc_q  <= '0;
      sec_q    <= '0;
      dur_q    <= DW'(1);
      walk_q   <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
      for (int unsigned t = 0; t < N_TABLES; t++) begin
        for (int unsigned p = 0; p < N_PHASES; p++) begin
          tab_q[t][p][0] <= TW'(10);
          tab_q[t][p][1] <= TW'(3);
          tab_q[t][p][2] <= TW'(1);
        end
      end
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      tblsel_q <= tblsel_d;
      latch_q  <= latch_d;
      mid_q    <= mid_d;
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      dur_q    <= dur_d;
      walk_q   <= walk_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      tab_q    <= tab_d;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer with TICKS_PER_SEC=4 and four phases.
module tb_phase_sequencer;

  logic       CLK = 1'b0;
  logic       reset_general;
  logic       enable_general;
  logic [1:0] tbl_sel;
  logic [3:0] demand;
  logic [3:0] ped_req;
  logic       cfg_we;
  logic [1:0] cfg_tbl;
  logic [1:0] cfg_phase;
  logic [1:0] cfg_field;
  logic [7:0] cfg_data;
  logic [3:0] green, yellow, red, walk;
  logic [1:0] cur_phase, cur_tbl;
  logic [2:0] state;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int bad_side = 0;
  bit mon_side = 1'b0;

  phase_sequencer #(
    .N_PHASES(4),
    .N_TABLES(4),
    .TW(8),
    .TICKS_PER_SEC(4)
  ) dut (
    .CLK(CLK),
    .reset_general(reset_general),
    .enable_general(enable_general),
    .tbl_sel(tbl_sel),
    .demand(demand),
    .ped_req(ped_req),
    .cfg_we(cfg_we),
    .cfg_tbl(cfg_tbl),
    .cfg_phase(cfg_phase),
    .cfg_field(cfg_field),
    .cfg_data(cfg_data),
    .green(green),
    .yellow(yellow),
    .red(red),
    .walk(walk),
    .cur_phase(cur_phase),
    .cur_tbl(cur_tbl),
    .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (mon_side && (green[1] | green[3] | yellow[1] | yellow[3])) bad_side++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  // Cycle 0 is the sample just after the last edge that saw reset low.
  task automatic do_reset();
    reset_general = 1'b0;
    step();
    step();
    reset_general = 1'b1;
    cyc = 0;
  endtask

  task automatic cfg_write(input logic [1:0] t, input logic [1:0] p,
                           input logic [1:0] f, input logic [7:0] d);
    cfg_we = 1'b1; cfg_tbl = t; cfg_phase = p; cfg_field = f; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    reset_general = 1'b0; enable_general = 1'b1; tbl_sel = 2'd0;
    demand = 4'b1111; ped_req = '0; cfg_we = 1'b0;
    cfg_tbl = '0; cfg_phase = '0; cfg_field = '0; cfg_data = '0;

    // Basic timing with full demand
    do_reset();
    check("rst_red", red, 4'b1111);
    check("rst_green", green, 4'b0000);
    check("rst_yellow", yellow, 4'b0000);
    check("rst_walk", walk, 4'b0000);
    check("rst_state", state, 3'd0);
    goto(3);  check("init_c3", green, 4'b0000);
    goto(4);  check("g0_c4", green, 4'b0001);
    check("g0_c4_red", red, 4'b1110);
    goto(43); check("g0_c43", green, 4'b0001);
    goto(44); check("y0_c44", yellow, 4'b0001);
    check("y0_c44_g", green, 4'b0000);
    goto(55); check("y0_c55", yellow, 4'b0001);
    goto(56); check("ar_c56", red, 4'b1111);
    goto(59); check("ar_c59", red, 4'b1111);
    goto(60); check("g1_c60", green, 4'b0010);
    check("g1_phase", cur_phase, 2'd1);

    // Demand on phases 0 and 2 only
    demand = 4'b0101;
    do_reset();
    mon_side = 1'b1;
    goto(4);   check("d_g0a", green, 4'b0001);
    goto(60);  check("d_g2a", green, 4'b0100);
    goto(116); check("d_g0b", green, 4'b0001);
    goto(172); check("d_g2b", green, 4'b0100);
    mon_side = 1'b0;
    check("d_side_red", bad_side, 0);

    // Pedestrian on phase 1 with short green
    demand = 4'b0000;
    do_reset();
    cfg_write(2'd0, 2'd1, 2'd0, 8'd2);
    goto(50);
    ped_req = 4'b0010;
    step();
    ped_req = '0;
    goto(59); check("p_walk_pre", walk, 4'b0000);
    goto(60); check("p_g1", green, 4'b0010);
    check("p_walk", walk, 4'b0010);
    goto(79); check("p_g1_end", green, 4'b0010);
    check("p_walk_end", walk, 4'b0010);
    goto(80); check("p_y1", yellow, 4'b0010);
    check("p_walk_off", walk, 4'b0000);
    goto(264); check("p_g1_again", green, 4'b0010);
    check("p_nowalk", walk, 4'b0000);
    goto(271); check("p_g1_short", green, 4'b0010);
    goto(272); check("p_y1_short", yellow, 4'b0010);

    // Table switch mid-cycle
    do_reset();
    goto(20);
    tbl_sel = 2'd1;
    cfg_write(2'd1, 2'd0, 2'd0, 8'd6);
    goto(43);  check("t_g0_old", green, 4'b0001);
    goto(44);  check("t_y0_old", yellow, 4'b0001);
    goto(227); check("t_tbl_held", cur_tbl, 2'd0);
    goto(228); check("t_g0_new", green, 4'b0001);
    check("t_tbl_new", cur_tbl, 2'd1);
    goto(251); check("t_g0_new_end", green, 4'b0001);
    goto(252); check("t_y0_new", yellow, 4'b0001);
    tbl_sel = 2'd0;

    // Flash mode
    do_reset();
    goto(10);
    enable_general = 1'b0;
    step();
    check("f_state", state, 3'd4);
    check("f_yel1", yellow, 4'b1111);
    check("f_red", red, 4'b0000);
    check("f_green", green, 4'b0000);
    goto(14); check("f_yel_c14", yellow, 4'b1111);
    goto(15); check("f_yel_c15", yellow, 4'b0000);
    goto(19); check("f_yel_c19", yellow, 4'b1111);
    goto(20);
    enable_general = 1'b1;
    step();
    check("f_init", state, 3'd0);
    check("f_init_red", red, 4'b1111);
    goto(24); check("f_pre_g", green, 4'b0000);
    goto(25); check("f_g0", green, 4'b0001);

    // Reset mid-yellow, with competing enable drop and config write
    do_reset();
    cfg_write(2'd0, 2'd0, 2'd0, 8'd2);
    goto(12); check("r_short_y", yellow, 4'b0001);
    goto(18);
    reset_general = 1'b0; enable_general = 1'b0;
    cfg_we = 1'b1; cfg_tbl = 2'd0; cfg_phase = 2'd0; cfg_field = 2'd0; cfg_data = 8'd7;
    step();
    reset_general = 1'b1; enable_general = 1'b1; cfg_we = 1'b0;
    cyc = 0;
    check("r_red", red, 4'b1111);
    check("r_yel", yellow, 4'b0000);
    check("r_state", state, 3'd0);
    goto(4);  check("r_g0", green, 4'b0001);
    goto(43); check("r_g0_dflt", green, 4'b0001);
    goto(44); check("r_y0_dflt", yellow, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
